// File: rtl/shader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shader_pkg
//  Description : Shared types and helpers for the shader core fetch path:
//                program-counter type, fetch FSM state encoding and the
//                opcode-to-length decode.
//  Revision    : 1.0 - initial release
// ============================================================================
package shader_pkg;

    // 12-bit byte address into shader program memory
    typedef logic unsigned [11:0] pc_t;

    // Fetch sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EMIT  = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_t;

    // Instruction length code (byte count minus one) lives in opcode[7:6]
    function automatic logic [1:0] instr_len_f(input logic [7:0] opcode);
        return opcode[7:6];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_watchdog
//  Description : Memory-response watchdog for the fetch unit. Counts cycles
//                spent waiting for a read completion and flags the cycle in
//                which the wait budget is used up. Only built when
//                FETCH_WATCHDOG_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_watchdog
    import shader_pkg::*;
#(
    parameter int unsigned WATCHDOG_CYCLES = 255
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(WATCHDOG_CYCLES + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Restart on every new request, count each waiting cycle
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_en) begin
            count_d = count_q + 1'b1;
        end
    end

    // Wait-cycle counter register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Asserted during the last permitted waiting cycle
    assign expired = count_en && (count_q == CNT_W'(WATCHDOG_CYCLES - 1));

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Shader instruction fetch stage. Issues byte reads to program
//                memory, assembles 1-4 byte little-endian instructions and
//                hands them downstream over valid/ready. Honours branch
//                redirects from the brancher.
//                Optional macro FETCH_WATCHDOG_EN adds a sticky fault when the
//                memory fails to answer within WATCHDOG_CYCLES.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import shader_pkg::*;
#(
    parameter pc_t         RESET_PC        = 12'h000,
    parameter int unsigned WATCHDOG_CYCLES = 255
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        rx_enable,
    output logic        mem_enable,
    output logic        mem_write,
    output logic        mem_strobe,
    output logic [11:0] mem_program_counter,
    input  logic [7:0]  mem_data,
    input  logic        mem_ready,
    input  logic        rx_branch_valid,
    input  logic [11:0] rx_branch_target,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] tx_instruction,
    output logic [1:0]  tx_length,
    output logic [11:0] tx_pc,
    output logic        tx_fault
);

    fetch_state_t state_q, state_d;
    pc_t          pc_q, pc_d;
    pc_t          tx_pc_q, tx_pc_d;
    pc_t          br_tgt_q, br_tgt_d;
    logic         br_pend_q, br_pend_d;
    logic [1:0]   idx_q, idx_d;
    logic [1:0]   len_q, len_d;
    logic [1:0]   len_new;
    logic [31:0]  instr_q, instr_d;
    logic         fault_q, fault_d;
    logic         mem_strobe_q, mem_strobe_d;
    logic         mem_enable_q, mem_enable_d;
    logic         tx_valid_q, tx_valid_d;
    logic         wd_expired;

`ifdef FETCH_WATCHDOG_EN
    fetch_watchdog #(
        .WATCHDOG_CYCLES (WATCHDOG_CYCLES)
    ) u_watchdog (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .clear    (mem_strobe_q),
        .count_en (state_q == ST_WAIT),
        .expired  (wd_expired)
    );
`else
    logic unused_wd_cfg;
    assign wd_expired    = 1'b0;
    assign unused_wd_cfg = ^WATCHDOG_CYCLES;
`endif

    // Next-state, assembly buffer and registered-output decode
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        tx_pc_d   = tx_pc_q;
        br_tgt_d  = br_tgt_q;
        br_pend_d = br_pend_q;
        idx_d     = idx_q;
        len_d     = len_q;
        instr_d   = instr_q;
        fault_d   = fault_q;
        // Slot 0 carries the opcode, so its length is taken straight off the bus
        len_new   = (idx_q == 2'd0) ? instr_len_f(mem_data) : len_q;

        case (state_q)
            ST_IDLE: begin
                if (rx_branch_valid) begin
                    pc_d    = rx_branch_target;
                    idx_d   = 2'd0;
                    len_d   = 2'd0;
                    instr_d = '0;
                    state_d = rx_enable ? ST_REQ : ST_IDLE;
                end else if (rx_enable) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // The strobe goes out regardless; a redirect waits for its reply
                state_d = ST_WAIT;
                if (rx_branch_valid) begin
                    br_pend_d = 1'b1;
                    br_tgt_d  = rx_branch_target;
                end
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    if (rx_branch_valid || br_pend_q) begin
                        pc_d      = rx_branch_valid ? rx_branch_target : br_tgt_q;
                        br_pend_d = 1'b0;
                        idx_d     = 2'd0;
                        len_d     = 2'd0;
                        instr_d   = '0;
                        state_d   = ST_REQ;
                    end else begin
                        instr_d[{idx_q, 3'b000} +: 8] = mem_data;
                        if (idx_q == 2'd0) begin
                            len_d   = len_new;
                            tx_pc_d = pc_q;
                        end
                        pc_d = pc_q + 12'd1;
                        if (idx_q == len_new) begin
                            state_d = ST_EMIT;
                        end else begin
                            idx_d   = idx_q + 2'd1;
                            state_d = rx_enable ? ST_REQ : ST_IDLE;
                        end
                    end
                end else begin
                    if (rx_branch_valid) begin
                        br_pend_d = 1'b1;
                        br_tgt_d  = rx_branch_target;
                    end
                    if (wd_expired) begin
                        fault_d   = 1'b1;
                        br_pend_d = 1'b0;
                        if (rx_branch_valid) begin
                            pc_d    = rx_branch_target;
                            idx_d   = 2'd0;
                            len_d   = 2'd0;
                            instr_d = '0;
                            state_d = ST_REQ;
                        end else begin
                            state_d = ST_FAULT;
                        end
                    end
                end
            end
            ST_EMIT: begin
                // Handshake and redirect can coincide: the word is consumed either way
                if (rx_branch_valid || tx_ready) begin
                    if (rx_branch_valid) begin
                        pc_d = rx_branch_target;
                    end
                    idx_d   = 2'd0;
                    len_d   = 2'd0;
                    instr_d = '0;
                    state_d = rx_enable ? ST_REQ : ST_IDLE;
                end
            end
`ifdef FETCH_WATCHDOG_EN
            ST_FAULT: begin
                if (rx_branch_valid) begin
                    pc_d    = rx_branch_target;
                    idx_d   = 2'd0;
                    len_d   = 2'd0;
                    instr_d = '0;
                    state_d = ST_REQ;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        mem_strobe_d = (state_d == ST_REQ);
        mem_enable_d = (state_d == ST_REQ) || (state_d == ST_WAIT);
        tx_valid_d   = (state_d == ST_EMIT);
    end

    // State, datapath and output registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            tx_pc_q      <= RESET_PC;
            br_tgt_q     <= '0;
            br_pend_q    <= 1'b0;
            idx_q        <= 2'd0;
            len_q        <= 2'd0;
            instr_q      <= '0;
            fault_q      <= 1'b0;
            mem_strobe_q <= 1'b0;
            mem_enable_q <= 1'b0;
            tx_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            tx_pc_q      <= tx_pc_d;
            br_tgt_q     <= br_tgt_d;
            br_pend_q    <= br_pend_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            instr_q      <= instr_d;
            fault_q      <= fault_d;
            mem_strobe_q <= mem_strobe_d;
            mem_enable_q <= mem_enable_d;
            tx_valid_q   <= tx_valid_d;
        end
    end

    assign mem_enable          = mem_enable_q;
    assign mem_write           = 1'b0;
    assign mem_strobe          = mem_strobe_q;
    assign mem_program_counter = pc_q;
    assign tx_valid            = tx_valid_q;
    assign tx_instruction      = instr_q;
    assign tx_length           = len_q;
    assign tx_pc               = tx_pc_q;
    assign tx_fault            = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit: directed vector table,
//                redirect / stall / reset sequences and a randomized run
//                checked against an instruction-stream reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        rx_enable;
    logic        mem_enable;
    logic        mem_write;
    logic        mem_strobe;
    logic [11:0] mem_program_counter;
    logic [7:0]  mem_data;
    logic        mem_ready;
    logic        rx_branch_valid;
    logic [11:0] rx_branch_target;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] tx_instruction;
    logic [1:0]  tx_length;
    logic [11:0] tx_pc;
    logic        tx_fault;

    always #5 aclk = ~aclk;

    fetch_unit #(
        .RESET_PC        (12'h000),
        .WATCHDOG_CYCLES (4)
    ) dut (
        .aclk                (aclk),
        .aresetn             (aresetn),
        .rx_enable           (rx_enable),
        .mem_enable          (mem_enable),
        .mem_write           (mem_write),
        .mem_strobe          (mem_strobe),
        .mem_program_counter (mem_program_counter),
        .mem_data            (mem_data),
        .mem_ready           (mem_ready),
        .rx_branch_valid     (rx_branch_valid),
        .rx_branch_target    (rx_branch_target),
        .tx_valid            (tx_valid),
        .tx_ready            (tx_ready),
        .tx_instruction      (tx_instruction),
        .tx_length           (tx_length),
        .tx_pc               (tx_pc),
        .tx_fault            (tx_fault)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [4096];
    int         mem_lat_max;
    bit         mem_hold;
    bit         mem_drop;

    // Memory responder: one reply per strobe, 0..mem_lat_max extra cycles late
    bit          r_pend;
    logic [11:0] r_addr;
    int          r_cnt;
    initial begin
        mem_ready = 1'b0;
        mem_data  = 8'h00;
        r_pend    = 1'b0;
        r_addr    = 12'h000;
        r_cnt     = 0;
        forever begin
            @(posedge aclk);
            #2;
            mem_ready = 1'b0;
            if (!aresetn || mem_drop) begin
                r_pend = 1'b0;
            end else if (r_pend) begin
                if (r_cnt == 0 && !mem_hold) begin
                    mem_ready = 1'b1;
                    mem_data  = mem[r_addr];
                    r_pend    = 1'b0;
                end else if (r_cnt != 0) begin
                    r_cnt = r_cnt - 1;
                end
            end else if (mem_strobe) begin
                r_pend = 1'b1;
                r_addr = mem_program_counter;
                r_cnt  = $urandom_range(0, mem_lat_max);
            end
        end
    end

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        rx_enable       = 1'b0;
        rx_branch_valid = 1'b0;
        tx_ready        = 1'b0;
        aresetn         = 1'b0;
        #1;
        check_eq("reset_ctl",
                 {mem_enable, mem_write, mem_strobe, mem_program_counter, tx_valid, tx_length, tx_pc, tx_fault},
                 {1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 2'd0, 12'h000, 1'b0});
        check_eq("reset_instr", tx_instruction, 32'h0);
        step();
        step();
        aresetn = 1'b1;
        step();
    endtask

    task automatic start_at(input logic [11:0] addr);
        rx_enable        = 1'b1;
        rx_branch_valid  = 1'b1;
        rx_branch_target = addr;
        step();
        rx_branch_valid  = 1'b0;
    endtask

    typedef struct {
        logic [11:0] start;
        logic [31:0] bytes;
        logic [31:0] exp_instr;
        logic [1:0]  exp_len;
        logic [11:0] next_pc;
        int          hold;
    } vec_t;

    vec_t vecs [6];

    initial begin : main
        int          cyc;
        int          n;
        int          hs_cnt;
        bit          stable;
        bit          seen;
        bit          br;
        bit          prev_chk;
        bit          prev_br;
        logic [11:0] a;
        logic [11:0] mpc;
        logic [7:0]  op;
        logic [31:0] exp_w;
        logic [31:0] p_instr;
        logic [1:0]  p_len;
        logic [11:0] p_pc;

        aresetn          = 1'b0;
        rx_enable        = 1'b0;
        rx_branch_valid  = 1'b0;
        rx_branch_target = 12'h000;
        tx_ready         = 1'b0;
        mem_hold         = 1'b0;
        mem_drop         = 1'b0;
        mem_lat_max      = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);

        vecs[0] = '{12'h000, 32'hDDCCBB05, 32'h00000005, 2'd0, 12'h001, 0};
        vecs[1] = '{12'h000, 32'h443322C1, 32'h443322C1, 2'd3, 12'h004, 10};
        vecs[2] = '{12'hFFF, 32'hEEEEEE01, 32'h00000001, 2'd0, 12'h000, 2};
        vecs[3] = '{12'h100, 32'h99887F4A, 32'h00007F4A, 2'd1, 12'h102, 0};
        vecs[4] = '{12'h200, 32'h55221180, 32'h00221180, 2'd2, 12'h203, 3};
        vecs[5] = '{12'hFFE, 32'hCCBBAAC0, 32'hCCBBAAC0, 2'd3, 12'h002, 1};

        step();

        // Directed vectors with zero-wait memory
        for (int v = 0; v < 6; v++) begin
            do_reset();
            for (int i = 0; i < 4; i++) begin
                a = vecs[v].start + 12'(i);
                mem[a] = vecs[v].bytes[i*8 +: 8];
            end
            start_at(vecs[v].start);
            check_eq("first_strobe", {mem_strobe, mem_program_counter}, {1'b1, vecs[v].start});
            cyc = 0;
            while (!tx_valid && cyc < 40) begin
                step();
                cyc++;
            end
            check_eq("latency", cyc, 2 * (int'(vecs[v].exp_len) + 1));
            check_eq("emit", {tx_instruction, tx_length, tx_pc},
                     {vecs[v].exp_instr, vecs[v].exp_len, vecs[v].start});
            stable = 1'b1;
            for (int h = 0; h < vecs[v].hold; h++) begin
                step();
                if (!tx_valid || mem_strobe || tx_instruction !== vecs[v].exp_instr) stable = 1'b0;
            end
            if (vecs[v].hold > 0) check_eq("hold_stable", stable, 1);
            tx_ready = 1'b1;
            step();
            tx_ready = 1'b0;
            check_eq("next_strobe", {mem_strobe, tx_valid, mem_program_counter},
                     {1'b1, 1'b0, vecs[v].next_pc});
        end

        // Redirect while waiting for byte 2 of a 3-byte opcode
        do_reset();
        mem[12'h300] = 8'h80;
        mem[12'h301] = 8'h11;
        mem[12'h302] = 8'h22;
        mem[12'h800] = 8'h05;
        start_at(12'h300);
        seen = 1'b0;
        n = 0;
        while (!(mem_strobe && mem_program_counter == 12'h301) && n < 20) begin
            if (tx_valid) seen = 1'b1;
            step();
            n++;
        end
        check_eq("br_reach", n < 20, 1);
        step();
        rx_branch_valid  = 1'b1;
        rx_branch_target = 12'h800;
        step();
        rx_branch_valid  = 1'b0;
        check_eq("br_strobe", {mem_strobe, tx_valid, mem_program_counter}, {1'b1, 1'b0, 12'h800});
        n = 0;
        while (!tx_valid && n < 20) begin
            step();
            n++;
        end
        check_eq("br_emit", {tx_valid, tx_instruction, tx_length, tx_pc}, {1'b1, 32'h5, 2'd0, 12'h800});
        check_eq("br_no_partial", seen, 0);

        // Memory that stops answering
        do_reset();
        mem[12'h050] = 8'h05;
        mem_hold = 1'b1;
        start_at(12'h050);
`ifdef FETCH_WATCHDOG_EN
        repeat (4) step();
        check_eq("wd_before", tx_fault, 0);
        step();
        check_eq("wd_fault", {tx_fault, mem_enable}, {1'b1, 1'b0});
        stable = 1'b1;
        repeat (10) begin
            step();
            if (mem_strobe || !tx_fault) stable = 1'b0;
        end
        check_eq("wd_quiet", stable, 1);
        mem_drop = 1'b1;
        step();
        mem_drop = 1'b0;
        mem_hold = 1'b0;
        start_at(12'h050);
        check_eq("wd_resume", {mem_strobe, mem_program_counter, tx_fault}, {1'b1, 12'h050, 1'b1});
        n = 0;
        while (!tx_valid && n < 20) begin
            step();
            n++;
        end
        check_eq("wd_emit", {tx_valid, tx_instruction, tx_fault}, {1'b1, 32'h5, 1'b1});
`else
        repeat (300) step();
        check_eq("wait_forever", {tx_fault, mem_enable, tx_valid, mem_strobe}, {1'b0, 1'b1, 1'b0, 1'b0});
        mem_hold = 1'b0;
        n = 0;
        while (!tx_valid && n < 20) begin
            step();
            n++;
        end
        check_eq("late_emit", {tx_valid, tx_instruction, tx_pc}, {1'b1, 32'h5, 12'h050});
`endif

        // Asynchronous reset while a read is in flight
        do_reset();
        mem[12'h040] = 8'h05;
        start_at(12'h040);
        #2;
        aresetn   = 1'b0;
        rx_enable = 1'b0;
        #1;
        check_eq("async_rst", {mem_strobe, mem_enable, mem_program_counter}, {1'b0, 1'b0, 12'h000});
        aresetn = 1'b1;
        step();
        step();
        step();
        check_eq("ignore_late_ready", {tx_valid, mem_enable}, {1'b0, 1'b0});
        rx_enable = 1'b1;
        step();
        check_eq("restart_pc", {mem_strobe, mem_program_counter}, {1'b1, 12'h000});

        // Randomized run against the instruction-stream model
        do_reset();
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        mem_lat_max = 2;
        mpc      = 12'h000;
        prev_chk = 1'b0;
        prev_br  = 1'b0;
        hs_cnt   = 0;
        p_instr  = '0;
        p_len    = '0;
        p_pc     = '0;
        for (int c = 0; c < 3000; c++) begin
            if (prev_chk)
                check_eq("hold_rnd", {tx_valid, tx_instruction, tx_length, tx_pc},
                         {1'b1, p_instr, p_len, p_pc});
            rx_enable        = ($urandom_range(0, 9) != 0);
            tx_ready         = ($urandom_range(0, 2) != 0);
            br               = !prev_br && ($urandom_range(0, 39) == 0);
            rx_branch_valid  = br;
            rx_branch_target = 12'($urandom);
            if (tx_valid && tx_ready) begin
                op    = mem[mpc];
                n     = int'(op[7:6]) + 1;
                exp_w = '0;
                for (int i = 0; i < n; i++) begin
                    a = mpc + 12'(i);
                    exp_w[i*8 +: 8] = mem[a];
                end
                check_eq("stream", {tx_instruction, tx_length, tx_pc}, {exp_w, 2'(n - 1), mpc});
                mpc = mpc + 12'(n);
                hs_cnt++;
            end
            if (br) mpc = rx_branch_target;
            prev_chk = tx_valid && !tx_ready && !br;
            p_instr  = tx_instruction;
            p_len    = tx_length;
            p_pc     = tx_pc;
            prev_br  = br;
            step();
        end
        rx_branch_valid = 1'b0;
        check_eq("progress", hs_cnt > 50, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the shader core. Drives the shader's byte-wide memory read port with a 12-bit program counter, assembles variable-length instructions (1–4 bytes) from the returned bytes, and presents them downstream on a valid/ready handshake. Accepts branch redirects from the brancher. Sits between the memory instance and the decode/execute logic inside `shader`.

## Interface
- `RESET_PC`, 12'h000, PC loaded on reset.
- `WATCHDOG_CYCLES`, 255, maximum cycles waiting for `mem_ready` before fault (only with `FETCH_WATCHDOG_EN`).
- `aclk`  in  1  clock; all logic on rising edge.
- `aresetn`  in  1  reset; asynchronous, active-low.
- `rx_enable`  in  1  fetch permitted; low = stop issuing new requests.
- `mem_enable`  out  1  memory enable; high whenever a request is outstanding.
- `mem_write`  out  1  tied 0 (read-only use).
- `mem_strobe`  out  1  one-cycle request pulse.
- `mem_program_counter`  out  12  byte address of request.
- `mem_data`  in  8  returned byte, valid when `mem_ready`.
- `mem_ready`  in  1  read completion, one cycle per strobe.
- `rx_branch_valid`  in  1  redirect request, single-cycle pulse.
- `rx_branch_target`  in  12  redirect address.
- `tx_valid`  out  1  instruction available.
- `tx_ready`  in  1  downstream accepts.
- `tx_instruction`  out  32  little-endian assembled instruction; opcode in [7:0], unused bytes zero.
- `tx_length`  out  2  byte count minus one.
- `tx_pc`  out  12  address of opcode byte.
- `tx_fault`  out  1  sticky watchdog fault (constant 0 without `FETCH_WATCHDOG_EN`).

## Operation
- States: IDLE, REQ, WAIT, EMIT, FAULT.
- IDLE: if `rx_enable` → REQ; else hold.
- REQ: `mem_strobe`=1 for exactly this cycle, `mem_program_counter`=pc → WAIT.
- WAIT: on `mem_ready`, store `mem_data` in byte slot `idx`, pc+1 (wraps 12'hFFF→12'h000). If slot 0, length = opcode[7:6] (00→1 … 11→4 bytes). If `idx`==length → EMIT; else REQ (or IDLE if `rx_enable` low).
- EMIT: `tx_valid`=1, outputs stable until `tx_valid && tx_ready`; then clear slots, `idx`=0 → REQ (IDLE if `rx_enable` low).
- Branch in IDLE/REQ/EMIT: discard partial/pending instruction, pc=target, `idx`=0, → REQ (IDLE if `rx_enable` low). REQ-cycle strobe still issues, so treat as WAIT-branch.
- Branch in WAIT: latch target; on `mem_ready` drop the byte, pc=target, → REQ.
- Branch coincident with EMIT handshake: handshake completes (instruction consumed), then redirect.
- Branch coincident with `mem_ready`: the byte is dropped.
- `rx_enable` low never aborts an outstanding memory read; EMIT output held until accepted.
- Reset mid-operation: all state cleared immediately; an in-flight `mem_ready` after reset is ignored (state IDLE).

## Timing
- Reset values: `mem_enable`=0, `mem_write`=0, `mem_strobe`=0, `mem_program_counter`=`RESET_PC`, `tx_valid`=0, `tx_instruction`=0, `tx_length`=0, `tx_pc`=`RESET_PC`, `tx_fault`=0; state IDLE, pc=`RESET_PC`.
- All outputs registered.
- `mem_ready` earliest one cycle after strobe. Zero-wait memory: N-byte instruction has `tx_valid` 2N cycles after first REQ cycle.
- Back-to-back: first REQ of next instruction the cycle after handshake.
- Branch-to-first-strobe: 1 cycle (from IDLE/EMIT).

## Configuration
- `FETCH_WATCHDOG_EN` defined: counter clears on each strobe, increments in WAIT; reaching `WATCHDOG_CYCLES` without `mem_ready` → FAULT, `tx_fault`=1 sticky, no strobes; only reset or branch exits (branch → REQ at target, fault flag stays set until reset).
- Not defined: no counter, no FAULT state, `tx_fault` tied 0, WAIT waits indefinitely.

## Structure
- `shader_pkg`: `pc_t` (logic unsigned [11:0]), `fetch_state_t` enum, `instr_len_f` function (opcode → length code).
- One sub-module: `fetch_watchdog` (counter + compare), instantiated only under `FETCH_WATCHDOG_EN`.

## Test plan
- Reset, zero-wait memory, bytes 8'h05 at 0: `tx_valid` cycle 2, `tx_instruction`=32'h05, `tx_length`=0, `tx_pc`=0.
- Bytes 8'hC1,8'h22,8'h33,8'h44 at 0: `tx_instruction`=32'h443322C1, `tx_length`=3, next strobe address 4.
- `tx_ready` held low 10 cycles: outputs stable, no strobe; single pulse → next strobe following cycle.
- Branch to 12'h800 during WAIT of byte 2 of a 3-byte opcode: returned byte dropped, next strobe 12'h800, no `tx_valid` for partial.
- 1-byte opcode at 12'hFFF: `tx_pc`=12'hFFF, next strobe 12'h000.
- With `FETCH_WATCHDOG_EN`, `WATCHDOG_CYCLES`=4, `mem_ready` never: `tx_fault`=1 after 4 WAIT cycles, no further strobes; branch resumes fetch, fault stays 1.
